ic_cpu_bus_bram_bridge_q: RTL
=============================

IC_CPU_BUS_BRAM_BRIDGE_Q -- requirements
Module: ic_cpu_bus_bram_bridge_q

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter AW, default 32, giving the address width in bits.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 2, giving the response buffer depth in entries (power of two, >=1).
REQ-004 The block SHALL have parameter MAP_BASE, default 32'h0000_0000, giving the first byte address mapped to BRAM.
REQ-005 The block SHALL have parameter MAP_SIZE, default 32'h0001_0000, giving the mapped window size in bytes.
REQ-006 The block SHALL have the following ports; reset is g_resetn, synchronous, active-low, and the clock is g_clk:
 g_clk  in  1  clock
 g_resetn  in  1  synchronous active-low reset
 enable  in  1  accept requests when high
 mem_req  in  1  request valid
 mem_gnt  out  1  request accepted this cycle
 mem_wen  in  1  write request
 mem_strb  in  DW/8  byte strobes
 mem_wdata  in  DW  write data
 mem_addr  in  AW  byte address
 mem_recv  out  1  response valid
 mem_ack  in  1  response consumed
 mem_error  out  1  response is an error
 mem_rdata  out  DW  response read data
 bram_cen  out  1  BRAM access enable
 bram_addr  out  AW  BRAM address (equal to mem_addr)
 bram_wdata  out  DW  BRAM write data
 bram_wstrb  out  DW/8  BRAM write strobes
 bram_stall  in  1  BRAM cannot accept this cycle
 bram_rdata  in  DW  BRAM read data, valid 1 cycle after accepted access

Function
REQ-007 The block SHALL keep pending flag P (plus error bit PE) set for exactly the cycle after any granted request.
REQ-008 The block SHALL keep a FIFO of RSP_DEPTH entries of {error, rdata}, with count C in 0..RSP_DEPTH.
REQ-009 The block SHALL drive mem_gnt = enable && !bram_stall && (C + P < RSP_DEPTH).
REQ-010 The block SHALL drive bram_cen = mem_req && mem_gnt && in_window, combinationally.
REQ-011 The block SHALL drive bram_wstrb = mem_wen ? mem_strb : 0, with bram_wdata = mem_wdata.
REQ-012 The block SHALL drive mem_recv = (C != 0) || P.
REQ-013 When C != 0, the block SHALL present the FIFO head on mem_rdata/mem_error; otherwise, when P, it SHALL present bram_rdata (0 if PE) and PE (bypass, 1-cycle latency).
REQ-014 The block SHALL push {PE, PE ? 0 : bram_rdata} when P && (C != 0 || !mem_ack).
REQ-015 The block SHALL pop when C != 0 && mem_ack.
REQ-016 Simultaneous push and pop SHALL leave C unchanged and preserve order.
REQ-017 Responses SHALL be returned in request order; mem_ack while mem_recv is low SHALL be ignored.
REQ-018 Pointers SHALL wrap modulo RSP_DEPTH; C SHALL never exceed RSP_DEPTH (guaranteed by REQ-009).
REQ-019 With RSP_DEPTH >= 2 and mem_ack held high, the block SHALL sustain one grant per cycle.
REQ-020 When enable is low, mem_gnt SHALL be 0; outstanding responses SHALL still drain.

Reset
REQ-021 On g_resetn low at a g_clk edge, P, PE, C and the pointers SHALL clear; mem_recv, mem_error and bram_cen SHALL then read 0.
REQ-022 Reset mid-operation SHALL discard all pending and buffered responses without a partial drain.
REQ-023 FIFO data storage SHALL NOT require reset.

Configuration
REQ-024 With IC_BRIDGE_ADDR_CHECK_EN defined, in_window = (mem_addr - MAP_BASE) < MAP_SIZE (unsigned, AW bits).
REQ-025 With IC_BRIDGE_ADDR_CHECK_EN defined, an out-of-window request SHALL be granted without bram_cen and SHALL respond with mem_error=1 and mem_rdata=0.
REQ-026 Without IC_BRIDGE_ADDR_CHECK_EN, in_window SHALL be 1, PE SHALL always be 0, and mem_error SHALL be tied 0.

Verification
REQ-027 Read at 0x100, mem_ack high -> mem_gnt=1 at cycle 0, bram_cen=1, mem_recv=1 at cycle 1, mem_rdata=bram_rdata.
REQ-028 Back-to-back reads 0x0,0x4,0x8, mem_ack held low for 3 cycles, RSP_DEPTH=2 -> third request not granted until first ack; data returned in order 0x0,0x4,0x8.
REQ-029 Write 0xDEADBEEF, strb 4'b0011 -> bram_wstrb=4'b0011; read with strb 4'b1111 -> bram_wstrb=0.
REQ-030 bram_stall=1 for 2 cycles with mem_req high -> mem_gnt=0 and bram_cen=0 in both cycles; grant in cycle 2.
REQ-031 IC_BRIDGE_ADDR_CHECK_EN, access 0x0001_0000 -> bram_cen=0, mem_recv=1 next cycle, mem_error=1, mem_rdata=0.
REQ-032 Reset asserted with C=2 -> mem_recv=0 the cycle after the reset edge; the next read returns fresh data with latency 1.

Source files
------------

// File: rtl/ic_cpu_bus_bram_bridge_q.sv
// CPU memory bus to single-cycle BRAM bridge with an in-order response queue.
// Define IC_BRIDGE_ADDR_CHECK_EN to enable window checking and error responses.
module ic_cpu_bus_bram_bridge_q #(
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int          RSP_DEPTH = 2,
  parameter logic [31:0] MAP_BASE  = 32'h0000_0000,
  parameter logic [31:0] MAP_SIZE  = 32'h0001_0000
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            enable,
  input  logic            mem_req,
  output logic            mem_gnt,
  input  logic            mem_wen,
  input  logic [DW/8-1:0] mem_strb,
  input  logic [DW-1:0]   mem_wdata,
  input  logic [AW-1:0]   mem_addr,
  output logic            mem_recv,
  input  logic            mem_ack,
  output logic            mem_error,
  output logic [DW-1:0]   mem_rdata,
  output logic            bram_cen,
  output logic [AW-1:0]   bram_addr,
  output logic [DW-1:0]   bram_wdata,
  output logic [DW/8-1:0] bram_wstrb,
  input  logic            bram_stall,
  input  logic [DW-1:0]   bram_rdata
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  if (MAP_SIZE == 32'd0 || (DW % 8) != 0 || RSP_DEPTH < 1 ||
      ({1'b0, MAP_BASE} + {1'b0, MAP_SIZE}) > 33'h1_0000_0000)
  begin : g_param_chk
    $error("ic_cpu_bus_bram_bridge_q: bad parameters");
  end

  logic          p_q;
  logic          pe_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [DW-1:0] data_mem [RSP_DEPTH];

  logic          in_window;
  logic          accept;
  logic          buf_nz;
  logic          push;
  logic          pop;
  logic [DW-1:0] byp_data;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef IC_BRIDGE_ADDR_CHECK_EN
  logic [AW-1:0] win_off;
  logic          err_mem [RSP_DEPTH];

  assign win_off   = mem_addr - AW'(MAP_BASE);
  assign in_window = win_off < AW'(MAP_SIZE);
  assign mem_error = buf_nz ? err_mem[rptr_q] : (p_q && pe_q);

  always_ff @(posedge g_clk) begin
    if (push) err_mem[wptr_q] <= pe_q;
  end
`else
  assign in_window = 1'b1;
  assign mem_error = 1'b0;
`endif

  // Occupancy counts the in-flight response (P) as well as buffered ones.
  assign occ      = {1'b0, cnt_q} + (CW+1)'(p_q);
  assign mem_gnt  = enable && !bram_stall && (occ < (CW+1)'(RSP_DEPTH));
  assign accept   = mem_req && mem_gnt;
  assign bram_cen = accept && in_window;

  assign bram_addr  = mem_addr;
  assign bram_wdata = mem_wdata;
  assign bram_wstrb = mem_wen ? mem_strb : '0;

  assign buf_nz   = cnt_q != '0;
  assign byp_data = pe_q ? '0 : bram_rdata;
  assign push     = p_q && (buf_nz || !mem_ack);
  assign pop      = buf_nz && mem_ack;

  assign mem_recv  = buf_nz || p_q;
  assign mem_rdata = buf_nz ? data_mem[rptr_q] : (p_q ? byp_data : '0);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      p_q    <= 1'b0;
      pe_q   <= 1'b0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      p_q  <= accept;
      pe_q <= accept && !in_window;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) data_mem[wptr_q] <= byp_data;
  end

endmodule
